tag_ctrl: RTL and testbench

//   Sequences the 128-bit tag register after the ASCON finalisation permutation.

---
 rtl/tag_ctrl.sv | 171 +++++++++++++++++
 tb/tb_tag_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_ctrl.sv
// -----------------------------------------------------------------------------
// tag_ctrl
//   Sequences the 128-bit ASCON tag register after the finalisation
//   permutation. On start_i the tag register is loaded, then the tag is either
//   streamed out word by word (encrypt) or compared word by word against a
//   received tag (decrypt). The comparison always consumes every word so the
//   decrypt path runs in constant time regardless of where a mismatch occurs.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   start_i      1-cycle pulse, finalisation done, tag valid upstream
//   mode_dec_i   sampled with start_i: 0 = encrypt/send, 1 = decrypt/check
//   abort_i      synchronous abort back to IDLE, no done_o
//   en_tag_o     tag register write enable (also high while in reset)
//   tag_q_i      tag register contents
//   tag_word_o   outgoing tag word, MS word first
//   tag_valid_o  tag_word_o valid
//   tag_ready_i  sink accepts tag_word_o
//   rx_word_i    received tag word, MS word first
//   rx_valid_i   rx_word_i valid
//   rx_ready_o   block accepts rx_word_i
//   busy_o       high in every state except IDLE
//   done_o       1-cycle completion pulse
//   auth_ok_o    decrypt verdict, only meaningful while done_o = 1
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start_i
// LOAD   | en_tag_o high for one cycle, tag register captures the tag
// SETTLE | one cycle for tag_q_i to reflect the new tag
// SEND   | presenting tag words to the sink (encrypt)
// RECV   | accepting received words and accumulating mismatch (decrypt)
// DONE   | done_o pulse with auth_ok_o verdict
// -----------------------------------------------------------------------------
module tag_ctrl #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              mode_dec_i,
    input  logic              abort_i,
    output logic              en_tag_o,
    input  logic [127:0]      tag_q_i,
    output logic [WORD_W-1:0] tag_word_o,
    output logic              tag_valid_o,
    input  logic              tag_ready_i,
    input  logic [WORD_W-1:0] rx_word_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              auth_ok_o
);

    localparam int NWORDS = 128 / WORD_W;
    localparam int CW     = $clog2(NWORDS) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_SEND,
        S_RECV,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mis_q, mis_d;
    logic            mode_q, mode_d;
    logic            load;
    logic [127:0]    tag_shift;
    logic [WORD_W-1:0] cur_word;

    // Shifting the current word to the top avoids a variable part-select
    // and gives MS-word-first ordering directly.
    assign tag_shift = tag_q_i << (WORD_W * int'(cnt_q));
    assign cur_word  = tag_shift[127 -: WORD_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mis_d       = mis_q;
        mode_d      = mode_q;
        load        = 1'b0;
        tag_valid_o = 1'b0;
        tag_word_o  = '0;
        rx_ready_o  = 1'b0;
        done_o      = 1'b0;
        auth_ok_o   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    mode_d  = mode_dec_i;
                    cnt_d   = '0;
                    mis_d   = 1'b0;
                end
            end
            S_LOAD: begin
                load    = 1'b1;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = mode_q ? S_RECV : S_SEND;
            end
            S_SEND: begin
                tag_valid_o = 1'b1;
                tag_word_o  = cur_word;
                if (tag_ready_i) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_RECV: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    // No early exit: every word is consumed so timing does
                    // not depend on the position of a mismatch.
                    mis_d = mis_q | (rx_word_i != cur_word);
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_o    = 1'b1;
                auth_ok_o = mode_q & ~mis_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides any handshake in the same cycle.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            mis_d   = 1'b0;
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    // Held high through reset so the tag register clears with the block.
    assign en_tag_o = ~reset | load;

endmodule

// File: tb/tb_tag_ctrl.sv
module tb_tag_ctrl;

    localparam int WORD_W = 32;
    localparam int NW     = 4;
    localparam logic [127:0] T1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] T2 = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;

    logic              clk = 1'b0;
    logic              reset;
    logic              start_i;
    logic              mode_dec_i;
    logic              abort_i;
    logic              en_tag_o;
    logic [127:0]      tag_q_i;
    logic [WORD_W-1:0] tag_word_o;
    logic              tag_valid_o;
    logic              tag_ready_i;
    logic [WORD_W-1:0] rx_word_i;
    logic              rx_valid_i;
    logic              rx_ready_o;
    logic              busy_o;
    logic              done_o;
    logic              auth_ok_o;

    logic [127:0]      tag_src;

    tag_ctrl #(.WORD_W(WORD_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .mode_dec_i  (mode_dec_i),
        .abort_i     (abort_i),
        .en_tag_o    (en_tag_o),
        .tag_q_i     (tag_q_i),
        .tag_word_o  (tag_word_o),
        .tag_valid_o (tag_valid_o),
        .tag_ready_i (tag_ready_i),
        .rx_word_i   (rx_word_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .auth_ok_o   (auth_ok_o)
    );

    always #5 clk = ~clk;

    // Tag register model: clears while reset is low, loads on en_tag_o.
    initial tag_q_i = 'x;
    always @(posedge clk) begin
        if (en_tag_o) tag_q_i <= reset ? tag_src : '0;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard of expected outgoing words, pushed when an encrypt op starts.
    logic [31:0] exp_q[$];
    int          sent_cnt = 0;
    int          rcv_cnt = 0;
    int          done_cnt = 0;
    bit          last_auth = 1'b0;
    bit          stall_prev = 1'b0;
    bit          final_hs_prev = 1'b0;
    logic [31:0] held_word = '0;

    always @(negedge clk) begin
        if (reset) begin
            if (!done_o) chk("auth_outside_done", {127'b0, auth_ok_o}, 128'd0);
            if (tag_valid_o && stall_prev) chk("word_held", tag_word_o, held_word);
            stall_prev = tag_valid_o && !tag_ready_i && !abort_i;
            held_word  = tag_word_o;
            if (done_o) begin
                done_cnt++;
                last_auth = auth_ok_o;
                chk("done_latency", {127'b0, final_hs_prev}, 128'd1);
            end
            final_hs_prev = 1'b0;
            if (tag_valid_o && tag_ready_i && !abort_i) begin
                if (exp_q.size() == 0) chk("sb_unexpected_word", 128'd1, 128'd0);
                else chk($sformatf("word%0d", sent_cnt), tag_word_o, exp_q.pop_front());
                sent_cnt++;
                if (sent_cnt == NW) final_hs_prev = 1'b1;
            end
            if (rx_valid_i && rx_ready_o && !abort_i) begin
                rcv_cnt++;
                if (rcv_cnt == NW) final_hs_prev = 1'b1;
            end
        end
    end

    typedef struct {
        string        name;
        bit           dec;
        logic [127:0] tag;
        logic [127:0] rx;
        bit           exp_auth;
        int           stall_word;
        int           stall_cyc;
        bit           start_pulse;
    } vec_t;

    function automatic vec_t mk(string nm, bit dec, logic [127:0] tag, logic [127:0] rx,
                                bit exp_auth, int stall_word, int stall_cyc, bit start_pulse);
        vec_t v;
        v.name = nm; v.dec = dec; v.tag = tag; v.rx = rx; v.exp_auth = exp_auth;
        v.stall_word = stall_word; v.stall_cyc = stall_cyc; v.start_pulse = start_pulse;
        return v;
    endfunction

    task automatic start_op(input bit dec, input logic [127:0] tag);
        logic [127:0] tmp;
        sent_cnt = 0; rcv_cnt = 0; final_hs_prev = 1'b0; stall_prev = 1'b0;
        tag_src = tag; mode_dec_i = dec; tag_ready_i = 1'b0; rx_valid_i = 1'b0;
        if (!dec) begin
            for (int i = 0; i < NW; i++) begin
                tmp = tag << (32 * i);
                exp_q.push_back(tmp[127:96]);
            end
        end
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic run_op(input vec_t v);
        int sd;
        int stall_left;
        bit pulsed;
        logic [127:0] tmp;
        sd = done_cnt;
        start_op(v.dec, v.tag);
        chk({v.name, "_load_en"}, {127'b0, en_tag_o}, 128'd1);
        chk({v.name, "_load_busy"}, {127'b0, busy_o}, 128'd1);
        step();
        chk({v.name, "_settle_en"}, {127'b0, en_tag_o}, 128'd0);
        chk({v.name, "_settle_valid"}, {126'b0, tag_valid_o, rx_ready_o}, 128'd0);
        step();
        chk({v.name, "_first_valid"}, {127'b0, v.dec ? rx_ready_o : tag_valid_o}, 128'd1);
        stall_left = v.stall_cyc;
        pulsed = 1'b0;
        for (int c = 0; c < 60 && done_cnt == sd; c++) begin
            if (!v.dec) begin
                if (sent_cnt == v.stall_word && stall_left > 0) begin
                    tag_ready_i = 1'b0;
                    stall_left--;
                end else begin
                    tag_ready_i = 1'b1;
                end
            end else begin
                rx_valid_i = (rcv_cnt < NW);
                tmp = v.rx << (32 * rcv_cnt);
                rx_word_i = tmp[127:96];
            end
            if (v.start_pulse && sent_cnt == 1 && !pulsed) begin
                start_i = 1'b1;
                pulsed = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            step();
        end
        tag_ready_i = 1'b0; rx_valid_i = 1'b0; start_i = 1'b0;
        chk({v.name, "_done"}, done_cnt - sd, 128'd1);
        chk({v.name, "_auth"}, {127'b0, last_auth}, {127'b0, v.exp_auth});
        chk({v.name, "_words"}, v.dec ? rcv_cnt : sent_cnt, NW);
        chk({v.name, "_sb_empty"}, exp_q.size(), 128'd0);
        repeat (3) step();
        chk({v.name, "_no_extra_done"}, done_cnt - sd, 128'd1);
        chk({v.name, "_idle"}, {127'b0, busy_o}, 128'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int sd;
        logic [127:0] tmp;
        vecs[0] = mk("enc_base",     0, T1, '0, 0, -1, 0, 0);
        vecs[1] = mk("enc_stall",    0, T1, '0, 0,  1, 2, 0);
        vecs[2] = mk("dec_match",    1, T1, T1, 1, -1, 0, 0);
        vecs[3] = mk("dec_w0_flip",  1, T1, T1 ^ (128'h1 << 96), 0, -1, 0, 0);
        vecs[4] = mk("dec_w3_flip",  1, T1, T1 ^ 128'h8000_0000, 0, -1, 0, 0);
        vecs[5] = mk("enc_start_in_send", 0, T2, '0, 0, -1, 0, 1);
        vecs[6] = mk("dec_w2_flip",  1, T2, T2 ^ (128'h1 << 40), 0, -1, 0, 0);

        reset = 1'b0; start_i = 1'b0; mode_dec_i = 1'b0; abort_i = 1'b0;
        tag_ready_i = 1'b0; rx_word_i = '0; rx_valid_i = 1'b0; tag_src = '0;
        #3;
        chk("rst_en_tag", {127'b0, en_tag_o}, 128'd1);
        chk("rst_outs", {122'b0, tag_valid_o, rx_ready_o, busy_o, done_o, auth_ok_o, |tag_word_o}, 128'd0);
        step(); step();
        reset = 1'b1;
        step();
        chk("rel_busy", {127'b0, busy_o}, 128'd0);
        chk("rel_en_tag", {127'b0, en_tag_o}, 128'd0);

        foreach (vecs[i]) run_op(vecs[i]);

        // Abort during RECV word 2 with a simultaneous handshake.
        sd = done_cnt;
        start_op(1'b1, T1);
        step(); step();
        for (int c = 0; c < 20 && rcv_cnt < 2; c++) begin
            rx_valid_i = 1'b1;
            tmp = (T1 ^ (128'h1 << 96)) << (32 * rcv_cnt);
            rx_word_i = tmp[127:96];
            step();
        end
        chk("abort_reached_w2", rcv_cnt, 128'd2);
        tmp = T1 << 64;
        rx_word_i = tmp[127:96];
        abort_i = 1'b1;
        step();
        abort_i = 1'b0; rx_valid_i = 1'b0;
        chk("abort_idle", {126'b0, busy_o, rx_ready_o}, 128'd0);
        chk("abort_wins", rcv_cnt, 128'd2);
        repeat (3) step();
        chk("abort_no_done", done_cnt - sd, 128'd0);
        run_op(mk("dec_after_abort", 1, T1, T1, 1, -1, 0, 0));

        // Reset asserted mid-SEND.
        sd = done_cnt;
        start_op(1'b0, T2);
        for (int c = 0; c < 20 && sent_cnt < 2; c++) begin
            tag_ready_i = 1'b1;
            step();
        end
        chk("rstmid_reached_w2", sent_cnt, 128'd2);
        #2 reset = 1'b0;
        #1;
        chk("rstmid_en_tag", {127'b0, en_tag_o}, 128'd1);
        chk("rstmid_outs", {122'b0, tag_valid_o, rx_ready_o, busy_o, done_o, auth_ok_o, |tag_word_o}, 128'd0);
        tag_ready_i = 1'b0;
        step();
        reset = 1'b1;
        exp_q.delete();
        repeat (3) step();
        chk("rstmid_no_done", done_cnt - sd, 128'd0);
        chk("rstmid_idle", {127'b0, busy_o}, 128'd0);
        run_op(mk("enc_after_reset", 0, T2, '0, 0, 2, 1, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
